// File: rtl/ptp_bridge_pkg.sv
// ---------------------------------------------------------------------------
// ptp_bridge_pkg
// Shared constants, types and helpers for the PTP bridge CSR blocks.
//   - RX DMA demux CSR word offsets and channel limit
//   - CAPS register field positions
//   - register-select enum and offset decoder for the demux CSR
//   - AVMM byte-enable helpers
// ---------------------------------------------------------------------------
package ptp_bridge_pkg;

    localparam int unsigned DMUX_MAX_CH = 16;

    // Demux CSR word offsets, relative to the block base address
    localparam int unsigned DMUX_CSR_CTRL        = 'h00;
    localparam int unsigned DMUX_CSR_CNT_CLR     = 'h01;
    localparam int unsigned DMUX_CSR_CAPS        = 'h02;
    localparam int unsigned DMUX_CSR_SAT         = 'h03;
    localparam int unsigned DMUX_CSR_THRESH_BASE = 'h10;
    localparam int unsigned DMUX_CSR_CNT_BASE    = 'h20;

    // CAPS field positions
    localparam int unsigned DMUX_CAPS_NUM_CH_LSB   = 0;
    localparam int unsigned DMUX_CAPS_NUM_CH_W     = 5;
    localparam int unsigned DMUX_CAPS_THRESH_W_LSB = 8;
    localparam int unsigned DMUX_CAPS_THRESH_W_W   = 6;
    localparam int unsigned DMUX_CAPS_CNT_W_LSB    = 16;
    localparam int unsigned DMUX_CAPS_CNT_W_W      = 6;

    typedef enum logic [2:0] {
        DMUX_SEL_NONE,
        DMUX_SEL_CTRL,
        DMUX_SEL_CNT_CLR,
        DMUX_SEL_CAPS,
        DMUX_SEL_SAT,
        DMUX_SEL_THRESH,
        DMUX_SEL_CNT
    } dmux_csr_sel_e;

    // Maps a word offset to a register class; per-channel classes only
    // match for channels that actually exist.
    function automatic dmux_csr_sel_e dmux_csr_decode(input logic [31:0] off,
                                                      input int unsigned num_ch);
        dmux_csr_sel_e sel;
        sel = DMUX_SEL_NONE;
        if (off == DMUX_CSR_CTRL) begin
            sel = DMUX_SEL_CTRL;
        end else if (off == DMUX_CSR_CNT_CLR) begin
            sel = DMUX_SEL_CNT_CLR;
        end else if (off == DMUX_CSR_CAPS) begin
            sel = DMUX_SEL_CAPS;
        end else if (off == DMUX_CSR_SAT) begin
            sel = DMUX_SEL_SAT;
        end else if (off >= DMUX_CSR_THRESH_BASE && off < DMUX_CSR_THRESH_BASE + num_ch) begin
            sel = DMUX_SEL_THRESH;
        end else if (off >= DMUX_CSR_CNT_BASE && off < DMUX_CSR_CNT_BASE + num_ch) begin
            sel = DMUX_SEL_CNT;
        end
        return sel;
    endfunction

    function automatic logic [31:0] dmux_caps_word(input int unsigned num_ch,
                                                   input int unsigned thresh_w,
                                                   input int unsigned cnt_w);
        logic [31:0] w;
        w = '0;
        w[DMUX_CAPS_NUM_CH_LSB   +: DMUX_CAPS_NUM_CH_W]   = num_ch[DMUX_CAPS_NUM_CH_W-1:0];
        w[DMUX_CAPS_THRESH_W_LSB +: DMUX_CAPS_THRESH_W_W] = thresh_w[DMUX_CAPS_THRESH_W_W-1:0];
        w[DMUX_CAPS_CNT_W_LSB    +: DMUX_CAPS_CNT_W_W]    = cnt_w[DMUX_CAPS_CNT_W_W-1:0];
        return w;
    endfunction

    function automatic logic [31:0] dmux_be_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

    function automatic logic [31:0] dmux_be_merge(input logic [31:0] old_val,
                                                  input logic [31:0] wdata,
                                                  input logic [3:0]  be);
        logic [31:0] m;
        m = dmux_be_mask(be);
        return (old_val & ~m) | (wdata & m);
    endfunction

endpackage

// File: rtl/dma_rx_dmux_drop_cnt.sv
// ---------------------------------------------------------------------------
// dma_rx_dmux_drop_cnt
// Saturating drop counter with clear and sticky saturation flag.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   inc_i       count one drop this cycle
//   clr_i       clear count and flag (a coincident inc_i still counts)
//   cnt_o       current count, holds at all-ones
//   sat_o       set on reaching all-ones, held until clr_i
// ---------------------------------------------------------------------------
module dma_rx_dmux_drop_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = inc_i ? CNT_W'(1) : '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        sat_d = (clr_i ? 1'b0 : sat_q) | (cnt_d == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/ptp_bridge_avmm_addr_chk.sv
// ---------------------------------------------------------------------------
// ptp_bridge_avmm_addr_chk
// Stage-1 register for an AVMM CSR slave: range-checks the word address
// against BASE_ADDR and registers offset, strobes, write data and byteenable.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   address_i        AVMM word address
//   read_i, write_i  AVMM strobes
//   writedata_i      write data
//   byteenable_i     write byte lanes
//   off_o            registered offset (address - BASE_ADDR)
//   in_range_o       registered: address >= BASE_ADDR
//   read_o, write_o  registered strobes (cleared by reset)
//   writedata_o      registered write data
//   byteenable_o     registered byteenable
// ---------------------------------------------------------------------------
module ptp_bridge_avmm_addr_chk #(
    parameter int unsigned BASE_ADDR  = 'h0,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic                  read_i,
    input  logic                  write_i,
    input  logic [31:0]           writedata_i,
    input  logic [3:0]            byteenable_i,
    output logic [ADDR_WIDTH-1:0] off_o,
    output logic                  in_range_o,
    output logic                  read_o,
    output logic                  write_o,
    output logic [31:0]           writedata_o,
    output logic [3:0]            byteenable_o
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    logic [ADDR_WIDTH-1:0] off_q;
    logic                  in_range_q;
    logic                  read_q;
    logic                  write_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q      <= '0;
            in_range_q <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            off_q      <= address_i - BASE;
            in_range_q <= (address_i >= BASE);
            read_q     <= read_i;
            write_q    <= write_i;
            wdata_q    <= writedata_i;
            be_q       <= byteenable_i;
        end
    end

    assign off_o        = off_q;
    assign in_range_o   = in_range_q;
    assign read_o       = read_q;
    assign write_o      = write_q;
    assign writedata_o  = wdata_q;
    assign byteenable_o = be_q;

endmodule

// File: rtl/dma_rx_dmux_csr_mc.sv
// ---------------------------------------------------------------------------
// dma_rx_dmux_csr_mc
// Multi-channel drop CSR for the PTP bridge RX DMA demux.
// Two-stage AVMM pipeline: stage 1 registers and range-checks the request,
// stage 2 applies writes and registers read data (valid 2 cycles after the
// read is sampled). cfg outputs are a further register of the CSR state.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   avmm_address          word address
//   avmm_read/_write      strobes, no waitrequest
//   avmm_writedata        write data
//   avmm_byteenable       write byte lanes
//   avmm_readdata(_valid) read response
//   cfg_drop_en           per-channel drop enable
//   cfg_drop_threshold    channel i at [i*THRESH_W +: THRESH_W]
//   drop_pulse            per-channel one-cycle drop indication
//   cnt_sat               per-channel sticky saturation flag
// ---------------------------------------------------------------------------
module dma_rx_dmux_csr_mc
    import ptp_bridge_pkg::*;
#(
    parameter int unsigned BASE_ADDR       = 'h0,
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned NUM_CH          = 8,
    parameter int unsigned THRESH_W        = 16,
    parameter int unsigned CNT_W           = 32,
    parameter logic [31:0] THRESH_RST      = 32'hFFFF,
    parameter bit          CNT_CLR_ON_READ = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_WIDTH-1:0]        avmm_address,
    input  logic                         avmm_read,
    output logic [31:0]                  avmm_readdata,
    output logic                         avmm_readdata_valid,
    input  logic                         avmm_write,
    input  logic [31:0]                  avmm_writedata,
    input  logic [3:0]                   avmm_byteenable,
    output logic [NUM_CH-1:0]            cfg_drop_en,
    output logic [NUM_CH*THRESH_W-1:0]   cfg_drop_threshold,
    input  logic [NUM_CH-1:0]            drop_pulse,
    output logic [NUM_CH-1:0]            cnt_sat
);

    if (NUM_CH < 1 || NUM_CH > DMUX_MAX_CH) begin : g_bad_num_ch
        $error("dma_rx_dmux_csr_mc: NUM_CH out of range");
    end

    localparam logic [THRESH_W-1:0] THRESH_RST_T = THRESH_W'(THRESH_RST);
    localparam logic [31:0]         CAPS_VAL     = dmux_caps_word(NUM_CH, THRESH_W, CNT_W);

    // ---------------- stage 1 ----------------
    logic [ADDR_WIDTH-1:0] s1_off;
    logic                  s1_in_range;
    logic                  s1_rd;
    logic                  s1_wr;
    logic [31:0]           s1_wdata;
    logic [3:0]            s1_be;

    ptp_bridge_avmm_addr_chk #(
        .BASE_ADDR  (BASE_ADDR),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_chk (
        .clk          (clk),
        .rst_n        (rst_n),
        .address_i    (avmm_address),
        .read_i       (avmm_read),
        .write_i      (avmm_write),
        .writedata_i  (avmm_writedata),
        .byteenable_i (avmm_byteenable),
        .off_o        (s1_off),
        .in_range_o   (s1_in_range),
        .read_o       (s1_rd),
        .write_o      (s1_wr),
        .writedata_o  (s1_wdata),
        .byteenable_o (s1_be)
    );

    logic [31:0]   off32;
    dmux_csr_sel_e sel;
    logic [3:0]    idx;

    assign off32 = 32'(s1_off);
    assign sel   = s1_in_range ? dmux_csr_decode(off32, NUM_CH) : DMUX_SEL_NONE;
    assign idx   = off32[3:0];

    // ---------------- state ----------------
    logic [NUM_CH-1:0]          ctrl_q, ctrl_d;
    logic [THRESH_W-1:0]        thresh_q [NUM_CH];
    logic [THRESH_W-1:0]        thresh_d [NUM_CH];
    logic [31:0]                rdata_q, rdata_d;
    logic                       rvalid_q;
    logic [NUM_CH-1:0]          cfg_en_q;
    logic [NUM_CH*THRESH_W-1:0] cfg_thr_q, cfg_thr_d;

    logic [CNT_W-1:0]           cnt [NUM_CH];
    logic [NUM_CH-1:0]          sat;
    logic [NUM_CH-1:0]          clr;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dma_rx_dmux_drop_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc_i (drop_pulse[g]),
            .clr_i (clr[g]),
            .cnt_o (cnt[g]),
            .sat_o (sat[g])
        );
    end

    // ---------------- stage 2: writes and clears ----------------
    always_comb begin
        ctrl_d   = ctrl_q;
        thresh_d = thresh_q;
        clr      = '0;
        if (s1_wr) begin
            case (sel)
                DMUX_SEL_CTRL: begin
                    ctrl_d = NUM_CH'(dmux_be_merge(32'(ctrl_q), s1_wdata, s1_be));
                end
                DMUX_SEL_CNT_CLR: begin
                    clr = NUM_CH'(s1_wdata & dmux_be_mask(s1_be));
                end
                DMUX_SEL_THRESH: begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (idx == 4'(i)) begin
                            thresh_d[i] = THRESH_W'(dmux_be_merge(32'(thresh_q[i]), s1_wdata, s1_be));
                        end
                    end
                end
                default: ;
            endcase
        end
        // Read-clear lands in the same edge that captures the read data,
        // so the response carries the pre-clear count.
        if (CNT_CLR_ON_READ && s1_rd && (sel == DMUX_SEL_CNT)) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (idx == 4'(i)) begin
                    clr[i] = 1'b1;
                end
            end
        end
    end

    // ---------------- stage 2: read mux ----------------
    always_comb begin
        rdata_d = '0;
        if (s1_rd) begin
            case (sel)
                DMUX_SEL_CTRL: rdata_d = 32'(ctrl_q);
                DMUX_SEL_CAPS: rdata_d = CAPS_VAL;
                DMUX_SEL_SAT:  rdata_d = 32'(sat);
                DMUX_SEL_THRESH: begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (idx == 4'(i)) begin
                            rdata_d = 32'(thresh_q[i]);
                        end
                    end
                end
                DMUX_SEL_CNT: begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (idx == 4'(i)) begin
                            rdata_d = 32'(cnt[i]);
                        end
                    end
                end
                default: rdata_d = '0;
            endcase
        end
    end

    always_comb begin
        cfg_thr_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cfg_thr_d[i*THRESH_W +: THRESH_W] = thresh_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            thresh_q  <= '{default: THRESH_RST_T};
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            cfg_en_q  <= '0;
            cfg_thr_q <= {NUM_CH{THRESH_RST_T}};
        end else begin
            ctrl_q    <= ctrl_d;
            thresh_q  <= thresh_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= s1_rd;
            cfg_en_q  <= ctrl_q;
            cfg_thr_q <= cfg_thr_d;
        end
    end

    assign avmm_readdata       = rdata_q;
    assign avmm_readdata_valid = rvalid_q;
    assign cfg_drop_en         = cfg_en_q;
    assign cfg_drop_threshold  = cfg_thr_q;
    assign cnt_sat             = sat;

endmodule

// File: tb/tb_dma_rx_dmux_csr_mc.sv
// Three instances share the AVMM request bus:
//   u_dut0 : defaults (base 0, 8 ch, 16-bit thresholds, 32-bit counters)
//   u_dut4 : CNT_W=4, base 0
//   u_dutc : CNT_CLR_ON_READ=1, base 0x80 (so base-0 accesses are below its base)
module tb_dma_rx_dmux_csr_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [7:0]  dp0, dp4, dpc;

    logic [31:0]  rdata0, rdata4, rdatac;
    logic         rv0, rv4, rvc;
    logic [7:0]   en0, en4, enc;
    logic [127:0] thr0, thr4, thrc;
    logic [7:0]   sat0, sat4, satc;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    logic [31:0] r0, r4, rc;

    dma_rx_dmux_csr_mc u_dut0 (
        .clk(clk), .rst_n(rst_n), .avmm_address(addr), .avmm_read(rd),
        .avmm_readdata(rdata0), .avmm_readdata_valid(rv0), .avmm_write(wr),
        .avmm_writedata(wdata), .avmm_byteenable(be), .cfg_drop_en(en0),
        .cfg_drop_threshold(thr0), .drop_pulse(dp0), .cnt_sat(sat0)
    );

    dma_rx_dmux_csr_mc #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .avmm_address(addr), .avmm_read(rd),
        .avmm_readdata(rdata4), .avmm_readdata_valid(rv4), .avmm_write(wr),
        .avmm_writedata(wdata), .avmm_byteenable(be), .cfg_drop_en(en4),
        .cfg_drop_threshold(thr4), .drop_pulse(dp4), .cnt_sat(sat4)
    );

    dma_rx_dmux_csr_mc #(.BASE_ADDR('h80), .CNT_CLR_ON_READ(1'b1)) u_dutc (
        .clk(clk), .rst_n(rst_n), .avmm_address(addr), .avmm_read(rd),
        .avmm_readdata(rdatac), .avmm_readdata_valid(rvc), .avmm_write(wr),
        .avmm_writedata(wdata), .avmm_byteenable(be), .cfg_drop_en(enc),
        .cfg_drop_threshold(thrc), .drop_pulse(dpc), .cnt_sat(satc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One AVMM transaction; for reads, checks valid is low one cycle after
    // sampling and high two cycles after, and captures all three readdatas.
    task automatic bus(input logic do_rd, input logic do_wr, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] b, input string tag);
        @(negedge clk);
        addr = a; rd = do_rd; wr = do_wr; wdata = d; be = b;
        @(posedge clk); #1;
        if (do_rd) chk({tag, " valid_early"}, 32'(rv0), 32'd0);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        if (do_rd) begin
            @(posedge clk); #1;
            chk({tag, " valid"}, 32'(rv0), 32'd1);
            r0 = rdata0; r4 = rdata4; rc = rdatac;
        end
    endtask

    task automatic pulses(input int unsigned which, input int unsigned ch, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clk);
            case (which)
                0:       dp0 = 8'd1 << ch;
                4:       dp4 = 8'd1 << ch;
                default: dpc = 8'd1 << ch;
            endcase
        end
        @(negedge clk);
        dp0 = '0; dp4 = '0; dpc = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0; be = '0;
        dp0 = '0; dp4 = '0; dpc = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst valid",   32'(rv0), 32'd0);
        chk("rst rdata",   rdata0, 32'd0);
        chk("rst en",      32'(en0), 32'd0);
        chk("rst thr3",    32'(thr0[63:48]), 32'hFFFF);
        chk("rst thr7",    32'(thr0[127:112]), 32'hFFFF);
        chk("rst sat",     32'(sat0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // CAPS and base handling
        bus(1, 0, 8'h02, 0, 4'hF, "caps");
        chk("caps dut0", r0, 32'h0020_1008);
        chk("caps dut4", r4, 32'h0004_1008);
        chk("below base dutc", rc, 32'd0);
        bus(1, 0, 8'h82, 0, 4'hF, "capsc");
        chk("caps dutc", rc, 32'h0020_1008);
        chk("unmapped 0x82 dut0", r0, 32'd0);
        bus(1, 0, 8'h10, 0, 4'hF, "thr0");
        chk("thr0 rst", r0, 32'h0000_FFFF);

        // CTRL write, cfg latency of 3 cycles
        bus(0, 1, 8'h00, 32'h0000_00A5, 4'hF, "wr ctrl");
        @(posedge clk); #1;
        chk("en not early", 32'(en0), 32'd0);
        @(posedge clk); #1;
        chk("en after 3", 32'(en0), 32'hA5);

        // THRESH[3] byte-lane write
        bus(0, 1, 8'h13, 32'h0000_1234, 4'b0001, "wr thr3");
        repeat (2) @(posedge clk);
        #1;
        chk("cfg thr3", 32'(thr0[63:48]), 32'hFF34);
        bus(1, 0, 8'h13, 0, 4'hF, "rd thr3");
        chk("rd thr3", r0, 32'h0000_FF34);

        // Counting and clear coinciding with a drop
        pulses(0, 2, 10);
        bus(1, 0, 8'h22, 0, 4'hF, "cnt2");
        chk("cnt2=10", r0, 32'd10);
        bus(0, 1, 8'h01, 32'h4, 4'hF, "clr2");
        dp0 = 8'h04;                  // lands on the clear edge
        @(negedge clk);
        dp0 = '0;
        bus(1, 0, 8'h22, 0, 4'hF, "cnt2b");
        chk("cnt2 clr+pulse", r0, 32'd1);

        // Saturation with a 4-bit counter
        pulses(4, 0, 14);
        bus(1, 0, 8'h20, 0, 4'hF, "c4a");
        chk("cnt4=14", r4, 32'd14);
        bus(1, 0, 8'h03, 0, 4'hF, "s4a");
        chk("sat4 not yet", r4, 32'd0);
        pulses(4, 0, 6);
        bus(1, 0, 8'h20, 0, 4'hF, "c4b");
        chk("cnt4 sat", r4, 32'd15);
        bus(1, 0, 8'h03, 0, 4'hF, "s4b");
        chk("sat4 reg", r4, 32'd1);
        chk("sat4 out", 32'(sat4), 32'd1);
        bus(0, 1, 8'h01, 32'h1, 4'hF, "clr0");
        bus(1, 0, 8'h20, 0, 4'hF, "c4c");
        chk("cnt4 cleared", r4, 32'd0);
        bus(1, 0, 8'h03, 0, 4'hF, "s4c");
        chk("sat4 cleared", r4, 32'd0);

        // Unmapped reads and writes
        bus(1, 0, 8'h28, 0, 4'hF, "u28");
        chk("rd 0x28", r0, 32'd0);
        bus(1, 0, 8'h7F, 0, 4'hF, "u7f");
        chk("rd 0x7F", r0, 32'd0);
        bus(1, 0, 8'h18, 0, 4'hF, "u18");
        chk("rd 0x18", r0, 32'd0);
        bus(0, 1, 8'h28, 32'hFFFF_FFFF, 4'hF, "w28");
        bus(0, 1, 8'h7F, 32'hFFFF_FFFF, 4'hF, "w7f");
        bus(0, 1, 8'h18, 32'hFFFF_FFFF, 4'hF, "w18");
        bus(0, 1, 8'h00, 32'hFFFF_FF5A, 4'b1110, "wctrl_nolane");
        bus(1, 0, 8'h00, 0, 4'hF, "ctrl");
        chk("ctrl kept", r0, 32'hA5);
        bus(1, 0, 8'h13, 0, 4'hF, "thr3k");
        chk("thr3 kept", r0, 32'hFF34);
        bus(1, 0, 8'h22, 0, 4'hF, "cnt2k");
        chk("cnt2 kept", r0, 32'd1);

        // Read and write in the same cycle
        bus(1, 1, 8'h00, 32'h0000_000F, 4'hF, "rw");
        chk("rw pre-write", r0, 32'hA5);
        bus(1, 0, 8'h00, 0, 4'hF, "ctrl2");
        chk("ctrl new", r0, 32'h0F);

        // Clear-on-read instance
        pulses(1, 1, 5);
        bus(1, 0, 8'hA1, 0, 4'hF, "cor1");
        chk("cor first", rc, 32'd5);
        bus(1, 0, 8'hA1, 0, 4'hF, "cor2");
        chk("cor second", rc, 32'd0);

        // Back-to-back reads, then reset with one still in flight
        @(negedge clk); rd = 1'b1; addr = 8'h02;
        @(posedge clk); #1;
        chk("pipe v0", 32'(rv0), 32'd0);
        @(negedge clk); addr = 8'h00;
        @(posedge clk); #1;
        chk("pipe v1", 32'(rv0), 32'd1);
        chk("pipe d1", rdata0, 32'h0020_1008);
        @(negedge clk); addr = 8'h13;
        @(posedge clk); #1;
        chk("pipe d2", rdata0, 32'h0F);
        @(negedge clk); addr = 8'h22;
        @(posedge clk); #1;
        chk("pipe d3", rdata0, 32'hFF34);
        @(negedge clk); rd = 1'b0; rst_n = 1'b0;
        #1;
        chk("mid rst valid", 32'(rv0), 32'd0);
        chk("mid rst rdata", rdata0, 32'd0);
        chk("mid rst en", 32'(en0), 32'd0);
        chk("mid rst en4", 32'(en4), 32'd0);
        chk("mid rst thr3", 32'(thr0[63:48]), 32'hFFFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("post rst no valid", 32'(rv0), 32'd0);
        end
        bus(1, 0, 8'h22, 0, 4'hF, "cnt2r");
        chk("cnt2 after rst", r0, 32'd0);
        bus(1, 0, 8'h00, 0, 4'hF, "ctrlr");
        chk("ctrl after rst", r0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
